// File: rtl/fmul_seq_ctrl_pkg.sv
// Shared definitions for the FP32 multiplier sequencer: state codes,
// FP constants and a small operand classification helper.
package fmul_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_EXP  = 3'd1;
  localparam state_t S_BIAS = 3'd2;
  localparam state_t S_MANT = 3'd3;
  localparam state_t S_PACK = 3'd4;
  localparam state_t S_DONE = 3'd5;
  localparam state_t S_RESP = 3'd6;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [7:0]  FP_BIAS = 8'd127;

  // True for +0/-0 (and only those, exponent and fraction all clear)
  function automatic logic fp_is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/fmul_seq_ctrl_if.sv
// Bus bundle between the sequencer, its operand producer / result consumer
// and the floatingpoint datapath.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid must not depend on ready; once raised, the sender keeps
// valid and its data stable until the transfer. in_valid/in_a/in_b and
// out_valid/out_data/out_ovf/out_err follow this rule.
interface fmul_seq_ctrl_if;
  // upstream operand port
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  // datapath operands and stage enables
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic [7:0]  dp_bias;
  logic        ENXor;
  logic        NEG1;
  logic        REG2;
  logic        MAN3;
  logic        OUT4;
  logic        REG4;
  logic        DONE5;
  logic        flag;
  // datapath results
  logic        Result;
  logic        overflow;
  logic [31:0] out;
  // downstream result port
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_err;

  // sequencer side
  modport slave (
    input  in_valid, in_a, in_b, Result, overflow, out, out_ready,
    output in_ready, dp_a, dp_b, dp_bias,
           ENXor, NEG1, REG2, MAN3, OUT4, REG4, DONE5, flag,
           out_valid, out_data, out_ovf, out_err
  );

  // environment side (producer, consumer and datapath)
  modport master (
    output in_valid, in_a, in_b, Result, overflow, out, out_ready,
    input  in_ready, dp_a, dp_b, dp_bias,
           ENXor, NEG1, REG2, MAN3, OUT4, REG4, DONE5, flag,
           out_valid, out_data, out_ovf, out_err
  );
endinterface

// File: rtl/fmul_seq_ctrl.sv
// Sequencer for the FP32 multiplier datapath. Accepts one operand pair,
// steps the datapath stage enables, waits (bounded) for the Result strobe
// and presents one product per accepted pair. No overlap between ops.
module fmul_seq_ctrl
  import fmul_pkg::*;
#(
  parameter logic [7:0] BIAS    = FP_BIAS,
  parameter int         TIMEOUT = 8,
  parameter int         TW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  fmul_seq_ctrl_if.slave bus,
  output state_t         dbg_state
);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] cnt;
  logic          z_r;
  logic          ovf_r;
  logic [31:0]   dp_a_r;
  logic [31:0]   dp_b_r;
  logic [31:0]   out_data_r;
  logic          out_ovf_r;
  logic          out_err_r;
  logic          tmo_hit;

  // last S_DONE cycle allowed before the op is completed as an error
  assign tmo_hit = (cnt == TW'(TIMEOUT - 1));

  // next-state decode; Result beats the timeout in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nx = S_EXP;
      S_EXP:   state_nx = S_BIAS;
      S_BIAS:  state_nx = S_MANT;
      S_MANT:  state_nx = S_PACK;
      S_PACK:  state_nx = S_DONE;
      S_DONE:  if (bus.Result || tmo_hit) state_nx = S_RESP;
      S_RESP:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // operand capture, overflow sample, timeout counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a_r     <= '0;
      dp_b_r     <= '0;
      z_r        <= 1'b0;
      ovf_r      <= 1'b0;
      cnt        <= '0;
      out_data_r <= '0;
      out_ovf_r  <= 1'b0;
      out_err_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dp_a_r <= bus.in_a;
            dp_b_r <= bus.in_b;
            z_r    <= fp_is_zero(bus.in_a) | fp_is_zero(bus.in_b);
          end
        end
        S_MANT: ovf_r <= bus.overflow;
        S_PACK: cnt <= '0;
        S_DONE: begin
          cnt <= cnt + TW'(1);
          if (bus.Result) begin
            // datapath has no zero handling, so a zero operand is fixed up here
            out_data_r <= z_r ? {dp_a_r[31] ^ dp_b_r[31], 31'd0} : bus.out;
            out_ovf_r  <= z_r ? 1'b0 : ovf_r;
            out_err_r  <= 1'b0;
          end else if (tmo_hit) begin
            out_data_r <= FP_QNAN;
            out_ovf_r  <= 1'b0;
            out_err_r  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore decode of stage enables and handshake flags from state only
  always_comb begin
    bus.ENXor     = 1'b0;
    bus.NEG1      = 1'b0;
    bus.REG2      = 1'b0;
    bus.MAN3      = 1'b0;
    bus.OUT4      = 1'b0;
    bus.REG4      = 1'b0;
    bus.DONE5     = 1'b0;
    bus.flag      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_IDLE: bus.in_ready = 1'b1;
      S_EXP: begin
        bus.ENXor = 1'b1;
        bus.NEG1  = 1'b1;
      end
      S_BIAS: begin
        bus.ENXor = 1'b1;
        bus.NEG1  = 1'b1;
        bus.REG2  = 1'b1;
      end
      S_MANT: begin
        bus.ENXor = 1'b1;
        bus.MAN3  = 1'b1;
      end
      S_PACK: begin
        bus.ENXor = 1'b1;
        bus.MAN3  = 1'b1;
        bus.OUT4  = 1'b1;
        bus.REG4  = 1'b1;
      end
      S_DONE: begin
        bus.DONE5 = 1'b1;
        bus.flag  = 1'b1;
      end
      S_RESP: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.dp_a     = dp_a_r;
  assign bus.dp_b     = dp_b_r;
  assign bus.dp_bias  = BIAS;
  assign bus.out_data = out_data_r;
  assign bus.out_ovf  = out_ovf_r;
  assign bus.out_err  = out_err_r;
  assign dbg_state    = state;

endmodule
